// File: rtl/uart_frame_rx.sv
// uart_frame_rx: UART receiver assembling little-endian bytes into indexed words of a fixed-length frame.
// Define UART_FRAME_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_frame_rx #(
    parameter int unsigned  CLK_FREQ_HZ  = 100_000_000,
    parameter int unsigned  BAUD_RATE    = 115200,
    parameter int unsigned  WORD_W       = 32,
    parameter int unsigned  NUM_WORDS    = 7,
    parameter int unsigned  TIMEOUT_BITS = 20,
    localparam int unsigned IDX_W        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic [IDX_W-1:0]  m_idx,
    output logic              m_last,
    output logic [3:0]        err_flags
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned WORD_BYTES   = WORD_W / 8;
    localparam int unsigned BYTE_W       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned TIMEOUT_CYC  = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TO_W         = $clog2(TIMEOUT_CYC + 1);

`ifdef UART_FRAME_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam state_t AFTER_DATA = PARITY;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t              state;
    state_t              state_nxt;
    logic                rx_meta;
    logic                rx_sync;
    logic [CNT_W-1:0]    clk_cnt;
    logic [2:0]          bit_cnt;
    logic [7:0]          shift;
    logic [BYTE_W-1:0]   byte_cnt;
    logic [IDX_W-1:0]    word_cnt;
    logic [WORD_W-1:0]   word_buf;
    logic [WORD_W-1:0]   word_full_c;
    logic [TO_W-1:0]     to_cnt;
    logic                par_bad;
    logic                half_c;
    logic                full_c;
    logic                cnt_clr_c;
    logic                bit_take_c;
    logic                byte_ok_c;
    logic                frame_err_c;
    logic                par_err_c;
    logic                word_end_c;

    assign half_c     = (clk_cnt == CNT_W'(HALF_BIT - 1));
    assign full_c     = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign word_end_c = (byte_cnt == BYTE_W'(WORD_BYTES - 1));

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rx_sync) state_nxt = START;
            START:   if (half_c) state_nxt = rx_sync ? IDLE : DATA;
            DATA:    if (full_c && bit_cnt == 3'd7) state_nxt = AFTER_DATA;
`ifdef UART_FRAME_RX_PARITY_EN
            PARITY:  if (full_c) state_nxt = STOP;
`endif
            STOP:    if (full_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes: sample points are mid-bit since START consumed half a bit period
    always_comb begin
        cnt_clr_c   = 1'b0;
        bit_take_c  = 1'b0;
        byte_ok_c   = 1'b0;
        frame_err_c = 1'b0;
        par_err_c   = 1'b0;
        case (state)
            IDLE:  cnt_clr_c = 1'b1;
            START: cnt_clr_c = half_c;
            DATA: begin
                cnt_clr_c  = full_c;
                bit_take_c = full_c;
            end
`ifdef UART_FRAME_RX_PARITY_EN
            PARITY: begin
                cnt_clr_c = full_c;
                par_err_c = full_c && (rx_sync != ^shift);
            end
`endif
            STOP: begin
                cnt_clr_c   = full_c;
                byte_ok_c   = full_c && rx_sync && !par_bad;
                frame_err_c = full_c && !rx_sync && !par_bad;
            end
            default: cnt_clr_c = 1'b1;
        endcase
    end

`ifdef UART_FRAME_RX_PARITY_EN
    // A parity failure is reported immediately; the following stop bit is then ignored
    always_ff @(posedge clk) begin
        if (rst)                 par_bad <= 1'b0;
        else if (state == START) par_bad <= 1'b0;
        else if (par_err_c)      par_bad <= 1'b1;
    end
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        word_full_c = word_buf;
        word_full_c[{byte_cnt, 3'b000} +: 8] = shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            word_buf  <= '0;
            to_cnt    <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_idx     <= '0;
            m_last    <= 1'b0;
            err_flags <= '0;
        end else begin
            err_flags <= '0;
            clk_cnt   <= cnt_clr_c ? '0 : clk_cnt + CNT_W'(1);

            if (state == START) bit_cnt <= '0;
            if (bit_take_c) begin
                shift   <= {rx_sync, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (m_valid && m_ready) m_valid <= 1'b0;

            // Completed word loads unless the previous one is still stalled
            if (byte_ok_c) begin
                word_buf <= word_full_c;
                if (word_end_c) begin
                    byte_cnt <= '0;
                    word_cnt <= (word_cnt == IDX_W'(NUM_WORDS - 1)) ? '0 : word_cnt + IDX_W'(1);
                    if (m_valid && !m_ready) begin
                        err_flags[2] <= 1'b1;
                    end else begin
                        m_valid <= 1'b1;
                        m_data  <= word_full_c;
                        m_idx   <= word_cnt;
                        m_last  <= (word_cnt == IDX_W'(NUM_WORDS - 1));
                    end
                end else begin
                    byte_cnt <= byte_cnt + BYTE_W'(1);
                end
            end

            if (frame_err_c || par_err_c) begin
                byte_cnt     <= '0;
                word_cnt     <= '0;
                err_flags[0] <= frame_err_c;
                err_flags[1] <= par_err_c;
            end

            // Inter-byte silence watchdog, armed only while a frame is partially received
            if (state != IDLE || (byte_cnt == '0 && word_cnt == '0)) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                to_cnt       <= '0;
                byte_cnt     <= '0;
                word_cnt     <= '0;
                err_flags[3] <= 1'b1;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed word table and corner-case sequences, then a random
// byte stream scored against a byte-list model of frame assembly.
module tb_uart_frame_rx;
    localparam int unsigned CLK_HZ    = 1_000_000;
    localparam int unsigned BAUD      = 125_000;
    localparam int unsigned CPB       = CLK_HZ / BAUD;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned NUM_WORDS = 7;
    localparam int unsigned TO_BITS   = 20;
    localparam int unsigned IDX_W     = 3;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  idx;
        logic        last;
    } word_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx  = 1'b1;
    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_data;
    logic [IDX_W-1:0]  m_idx;
    logic              m_last;
    logic [3:0]        err_flags;

    int    vectors     = 0;
    int    miscompares = 0;
    int    err_cnt [4] = '{0, 0, 0, 0};
    int    rdy_mode    = 1;
    word_t got_q [$];

    uart_frame_rx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD),
        .WORD_W      (WORD_W),
        .NUM_WORDS   (NUM_WORDS),
        .TIMEOUT_BITS(TO_BITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_idx    (m_idx),
        .m_last   (m_last),
        .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    initial begin
        repeat (200_000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog expired");
    end

    // Consumer: forced low, forced high, or random with a bounded stall
    initial begin
        int low_run;
        low_run = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: m_ready = 1'b0;
                1: m_ready = 1'b1;
                default: begin
                    if (low_run >= 12) m_ready = 1'b1;
                    else               m_ready = ($urandom_range(0, 2) != 0);
                    low_run = m_ready ? 0 : low_run + 1;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (err_flags[i]) err_cnt[i]++;
        if (m_valid && m_ready) got_q.push_back('{m_data, m_idx, m_last});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_FRAME_RX_PARITY_EN
        send_bit(par);
`else
        if (par !== par) rx = 1'b1;
`endif
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1, ^w[8*k +: 8]);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2 * CPB);
    endtask

    task automatic take_word(input string name, input logic [31:0] d, input logic [2:0] idx,
                             input logic last);
        word_t w;
        int    n;
        n = 0;
        while (got_q.size() == 0 && n < 20 * CPB) begin
            @(negedge clk);
            n++;
        end
        check({name, "_present"}, 64'(got_q.size() > 0), 64'd1);
        if (got_q.size() > 0) begin
            w = got_q.pop_front();
            check(name, {w.data, w.idx, w.last}, {d, idx, last});
        end
    endtask

    initial begin
        word_t       tbl [7];
        word_t       exp_q [$];
        word_t       w;
        logic [7:0]  mbytes [$];
        logic [7:0]  d;
        logic        bad;
        int          e0, e1, e2, e3, midx, exp_ferr, n;

        tbl[0] = '{32'h0000_2710, 3'd0, 1'b0};
        tbl[1] = '{32'h0000_0032, 3'd1, 1'b0};
        tbl[2] = '{32'h0064_0000, 3'd2, 1'b0};
        tbl[3] = '{32'h0064_0000, 3'd3, 1'b0};
        tbl[4] = '{32'h0000_CCC0, 3'd4, 1'b0};
        tbl[5] = '{32'h0003_3333, 3'd5, 1'b0};
        tbl[6] = '{32'h0001_0000, 3'd6, 1'b1};

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_m_idx", 64'(m_idx), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_err_flags", 64'(err_flags), 64'd0);
        rst = 1'b0;
        idle(4 * CPB);

        // Parameter frame, consumer always ready
        for (int i = 0; i < 7; i++) begin
            send_word(tbl[i].data);
            take_word($sformatf("frame_w%0d", i), tbl[i].data, tbl[i].idx, tbl[i].last);
        end
        idle(2 * CPB);
        check("frame_no_errors", 64'(err_cnt[0] + err_cnt[1] + err_cnt[2] + err_cnt[3]), 64'd0);

        // Framing error resynchronises to word 0
        e0 = err_cnt[0];
        send_byte(8'h10, 1'b0, ^8'h10);
        idle(3 * CPB);
        send_word(32'hDEAD_BEEF);
        take_word("framing_next", 32'hDEAD_BEEF, 3'd0, 1'b0);
        check("framing_pulses", 64'(err_cnt[0] - e0), 64'd1);

        // Overrun keeps the stalled word, counter still advances
        rst_pulse();
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        got_q.delete();
        e2 = err_cnt[2];
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        idle(2 * CPB);
        check("ovr_valid", 64'(m_valid), 64'd1);
        check("ovr_data_held", 64'(m_data), 64'h1111_1111);
        check("ovr_idx_held", 64'(m_idx), 64'd0);
        check("ovr_pulses", 64'(err_cnt[2] - e2), 64'd1);
        rdy_mode = 1;
        take_word("ovr_drain", 32'h1111_1111, 3'd0, 1'b0);
        send_word(32'h3333_3333);
        take_word("ovr_next_idx", 32'h3333_3333, 3'd2, 1'b0);

        // Idle timeout on a partial word
        rst_pulse();
        e3 = err_cnt[3];
        send_byte(8'h5A, 1'b1, ^8'h5A);
        send_byte(8'hC3, 1'b1, ^8'hC3);
        idle((TO_BITS + 4) * CPB);
        check("timeout_pulse", 64'(err_cnt[3] - e3), 64'd1);
        idle((TO_BITS + 4) * CPB);
        check("timeout_once", 64'(err_cnt[3] - e3), 64'd1);
        send_word(32'hA5A5_A5A5);
        take_word("timeout_next", 32'hA5A5_A5A5, 3'd0, 1'b0);

        // Reset mid-byte discards the partial word
        rst_pulse();
        got_q.delete();
        e0 = err_cnt[0];
        send_byte(8'hAB, 1'b1, ^8'hAB);
        send_byte(8'hCD, 1'b1, ^8'hCD);
        fork
            send_byte(8'hFF, 1'b1, ^8'hFF);
            begin
                repeat (5 * CPB) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        idle(2 * CPB);
        send_word(32'h1234_5678);
        idle(2 * CPB);
        check("midrst_count", 64'(got_q.size()), 64'd1);
        take_word("midrst_word", 32'h1234_5678, 3'd0, 1'b0);
        check("midrst_no_frame_err", 64'(err_cnt[0] - e0), 64'd0);

`ifdef UART_FRAME_RX_PARITY_EN
        rst_pulse();
        got_q.delete();
        e1 = err_cnt[1];
        send_byte(8'h01, 1'b1, 1'b0);
        idle(2 * CPB);
        check("parity_pulse", 64'(err_cnt[1] - e1), 64'd1);
        check("parity_no_word", 64'(got_q.size()), 64'd0);
        send_word(32'hCAFE_F00D);
        take_word("parity_next", 32'hCAFE_F00D, 3'd0, 1'b0);
`else
        e1 = 0;
`endif

        // Random stream against the byte-list model
        rst_pulse();
        got_q.delete();
        rdy_mode = 2;
        e0 = err_cnt[0];
        e1 = err_cnt[1];
        e2 = err_cnt[2];
        midx = 0;
        exp_ferr = 0;
        for (int b = 0; b < 80; b++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 9) == 0);
            send_byte(d, !bad, ^d);
            if (bad) begin
                idle(3 * CPB);
                mbytes.delete();
                midx = 0;
                exp_ferr++;
            end else begin
                idle(int'($urandom_range(0, 4)) * CPB);
                mbytes.push_back(d);
                if (mbytes.size() == 4) begin
                    w.data = {mbytes[3], mbytes[2], mbytes[1], mbytes[0]};
                    w.idx  = 3'(midx);
                    w.last = (midx == NUM_WORDS - 1);
                    exp_q.push_back(w);
                    midx = (midx + 1) % NUM_WORDS;
                    mbytes.delete();
                end
            end
        end
        idle(4 * CPB);
        check("rand_word_count", 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("rand_w%0d", i), {got_q[i].data, got_q[i].idx, got_q[i].last},
                  {exp_q[i].data, exp_q[i].idx, exp_q[i].last});
        check("rand_framing_pulses", 64'(err_cnt[0] - e0), 64'(exp_ferr));
        check("rand_no_overrun", 64'(err_cnt[2] - e2), 64'd0);
        check("rand_no_parity_err", 64'(err_cnt[1] - e1), 64'd0);
`ifndef UART_FRAME_RX_PARITY_EN
        check("parity_flag_tied", 64'(err_cnt[1]), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 100_000_000, meaning the system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, meaning the serial bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE, integer-truncated.
REQ-003 The block SHALL have parameter WORD_W, default 32, meaning output word width; it must be a multiple of 8, range 8..64; WORD_BYTES = WORD_W/8.
REQ-004 The block SHALL have parameter NUM_WORDS, default 7, meaning words per parameter frame, range 1..256; IDX_W = max(1,$clog2(NUM_WORDS)).
REQ-005 The block SHALL have parameter TIMEOUT_BITS, default 20, meaning idle bit-periods after which a partial frame is discarded.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-008 The block SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-009 The block SHALL have port m_valid, output, 1, meaning the output word is valid.
REQ-010 The block SHALL have port m_ready, input, 1, meaning the consumer accepts the word.
REQ-011 The block SHALL have port m_data, output, WORD_W, holding the assembled word.
REQ-012 The block SHALL have port m_idx, output, IDX_W, giving the word position in the frame (0..NUM_WORDS-1).
REQ-013 The block SHALL have port m_last, output, 1, high when m_idx == NUM_WORDS-1.
REQ-014 The block SHALL have port err_flags, output, 4, one-cycle pulses {timeout, overrun, parity, framing}, bits [3:0].

Function
REQ-015 rx SHALL pass through a 2-FF synchroniser; all decisions SHALL use the synchronised value.
REQ-016 The bit FSM SHALL use states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-017 IDLE->START SHALL occur on synchronised rx low; START SHALL re-sample at CLKS_PER_BIT/2 and return to IDLE if high (glitch), else go to DATA.
REQ-018 DATA SHALL sample 8 bits, LSB first, each CLKS_PER_BIT after the previous sample.
REQ-019 STOP SHALL sample once; high accepts the byte, and low drops it, pulses err_flags[0], resets the byte and word counters to 0, and discards the partial frame.
REQ-020 Accepted bytes SHALL assemble little-endian: byte k of a word SHALL go to bits [8k+7:8k].
REQ-021 When byte WORD_BYTES-1 is accepted, the word SHALL load the output register with m_valid=1 on the next cycle; m_idx SHALL be the word counter, which SHALL increment and wrap from NUM_WORDS-1 to 0.
REQ-022 m_data, m_idx and m_last SHALL hold stable while m_valid=1 and m_ready=0; the transfer SHALL occur on a cycle with m_valid && m_ready.
REQ-023 If a word completes while m_valid=1 and m_ready=0, the new word SHALL be dropped, the old word SHALL be kept, err_flags[2] SHALL pulse, and the word counter SHALL still advance.
REQ-024 If a word completes on the same cycle an accept occurs, the new word SHALL load without overrun.
REQ-025 With a byte or word counter nonzero and no start bit for TIMEOUT_BITS*CLKS_PER_BIT cycles, both counters SHALL clear and err_flags[3] SHALL pulse once; no timeout SHALL fire when both counters are 0.

Reset
REQ-026 While rst=1, the block SHALL set m_valid=0, m_data=0, m_idx=0, m_last=0, err_flags=0, FSM=IDLE, all counters=0, and synchroniser FFs=1.
REQ-027 Reset asserted mid-byte or mid-frame SHALL discard all partial data; the first start bit after release SHALL be treated as byte 0 of word 0.

Configuration
REQ-028 With macro UART_FRAME_RX_PARITY_EN defined, an even-parity bit SHALL follow data and be checked in PARITY; a mismatch SHALL drop the byte, pulse err_flags[1], and resync the counters as in REQ-019.
REQ-029 Without UART_FRAME_RX_PARITY_EN, no PARITY state SHALL exist, the frame SHALL be 8N1, and err_flags[1] SHALL be tied 0.

Verification
REQ-030 Defaults with m_ready=1: send 7 words 0x00002710, 0x00000032, 0x00640000, 0x00640000, 0x0000CCC0, 0x00033333, 0x00010000 as 28 LSB-first bytes -> identical m_data sequence, m_idx 0..6, m_last only on idx 6, err_flags 0.
REQ-031 Send byte 0x10 with stop bit low, then a full word 0xDEADBEEF -> err_flags[0] pulses once; the next output is 0xDEADBEEF with m_idx=0.
REQ-032 Hold m_ready=0 and send 2 words 0x11111111 and 0x22222222 -> m_data stays 0x11111111, err_flags[2] pulses once; after m_ready=1, the next word sent has m_idx=2.
REQ-033 Send 2 bytes, then idle 20*868 cycles -> err_flags[3] pulses once; the next word 0xA5A5A5A5 outputs with m_idx=0.
REQ-034 Assert rst for 1 cycle midway through the 3rd byte, then send 0x12345678 -> single output 0x12345678, m_idx=0.
REQ-035 With UART_FRAME_RX_PARITY_EN, send byte 0x01 with parity bit 0 -> err_flags[1] pulses and no word is output.
